sequential_divider: RTL and testbench
=====================================

Name: sequential_divider

Overview:
- Signed iterative divider using shift and subtract (restoring algorithm). It is the inverse counterpart of the shift-and-add multiplier in the arithmetic datapath.
- Takes a WIDTH-bit dividend and divisor and produces the quotient and remainder after WIDTH iterations, at one quotient bit per clock.
- Uses a start/busy/done handshake so a controller can issue operations back to back.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement)

Ports:
- i_clk  input  1  clock; all state changes on the rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_start  input  1  request; sampled only in IDLE
- i_dividend  input  WIDTH  signed dividend; sampled on the accept edge only
- i_divisor  input  WIDTH  signed divisor; sampled on the accept edge only
- o_busy  output  1  high while an operation is in progress (ITER or FIX)
- o_done  output  1  one-cycle pulse; results valid from this cycle
- o_quotient  output  WIDTH  signed quotient, held until the next o_done
- o_remainder  output  WIDTH  signed remainder, held until the next o_done
- o_div_by_zero  output  1  flag for the last completed operation, held with the results

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous, active-high, and takes priority over everything else.
- Reset values:
  - state=IDLE, iteration counter=0, internal registers=0.
  - o_busy=0, o_done=0, o_quotient=0, o_remainder=0, o_div_by_zero=0.
- States: IDLE, ITER, FIX.
- IDLE:
  - o_busy=0.
  - An edge with i_start=1 is the accept edge.
  - If i_divisor!=0 at the accept edge:
    - latch |dividend| into Q, |divisor| into D (WIDTH-bit unsigned magnitudes);
    - clear R (WIDTH+1 bits); latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend);
    - set counter=0 and go to ITER.
  - If i_divisor==0 at the accept edge (divide-by-zero):
    - no iterations; stay in IDLE;
    - at that same edge load o_quotient = all ones, o_remainder = i_dividend, o_div_by_zero=1, o_done=1.
    - Latency is 1 edge.
- ITER (one step per edge, WIDTH edges):
  - shift {R,Q} left by 1;
  - trial = R_shifted − {0,D}, computed at WIDTH+1 bits;
  - if trial is non-negative: R=trial and the new Q LSB=1; otherwise R=R_shifted and the new Q LSB=0;
  - counter increments; after step WIDTH, go to FIX.
- FIX (one edge):
  - o_quotient = sign_q ? −Q : Q; o_remainder = sign_r ? −R[WIDTH-1:0] : R[WIDTH-1:0];
  - o_div_by_zero=0, o_done=1, go to IDLE.
- Latency: for a nonzero divisor, o_done rises WIDTH+1 edges after the accept edge (33 for WIDTH=32). o_busy is high for exactly WIDTH+1 cycles.
- o_done is 0 on every edge except a completion edge.
- Arithmetic semantics:
  - Truncation toward zero; the remainder takes the sign of the dividend.
  - Invariant: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Overflow: MIN / −1 yields quotient = MIN (0x80000000 for WIDTH=32), remainder 0, no flag. The magnitude path handles this naturally, since |MIN| fits in WIDTH unsigned bits.
- i_start while busy: ignored. The operation in flight is unaffected and nothing is queued.
- Back-to-back: i_start=1 in the o_done cycle (state is IDLE) is accepted. The new operation starts and the previous results stay on the outputs until the new o_done.
- Operand changes after the accept edge have no effect.
- Reset mid-operation: the next edge returns all state and outputs to reset values. No o_done is produced for the aborted operation.

Test Plan:
- Positive operands: dividend=100, divisor=7, start one cycle -> o_done exactly 33 edges after the accept edge; quotient=14, remainder=2, o_div_by_zero=0; o_busy high for 33 cycles.
- Signed combinations:
  - −100/7 -> quotient −14 (0xFFFFFFF2), remainder −2;
  - 100/−7 -> quotient −14, remainder 2;
  - −100/−7 -> quotient 14, remainder −2;
  - 0/5 -> quotient 0, remainder 0.
- Edge operands:
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0;
  - 5/9 -> quotient 0, remainder 5;
  - 0x7FFFFFFF/1 -> quotient 0x7FFFFFFF, remainder 0.
- Divide by zero: −12 / 0 -> o_done one edge after accept, quotient 0xFFFFFFFF, remainder 0xFFFFFFF4, o_div_by_zero=1. A following 12/13 completes normally (quotient 0, remainder 12) and clears the flag.
- Handshake:
  - start 12/13, then pulse i_start with 50/5 at edge 10 -> ignored; the result is quotient 0, remainder 12 at edge 33;
  - then assert i_start with 50/5 in the o_done cycle -> accepted; quotient 10, remainder 0 after a further 33 edges.
- Reset: assert i_rst for one cycle at edge 15 of 100/7 -> all outputs 0 and o_busy 0 on the next edge, no o_done; a subsequent 100/7 completes correctly.

Source files
------------

// File: rtl/sequential_divider.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// with the signs of the quotient and remainder restored in a final fix-up cycle.
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t            state, next_state;
    logic [WIDTH-1:0]  q_reg, d_reg;
    logic [WIDTH:0]    r_reg;
    logic              sign_q, sign_r;
    logic [CW-1:0]     count;
    logic              accept;
    logic              divisor_zero;
    logic [WIDTH-1:0]  dividend_mag, divisor_mag;
    logic [WIDTH:0]    r_shift, trial;

    // |MIN| wraps back to MIN, which is still the correct unsigned magnitude.
    assign divisor_zero = (i_divisor == '0);
    assign dividend_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign divisor_mag  = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
    assign r_shift      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign trial        = r_shift - {1'b0, d_reg};

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_busy     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = i_start;
                if (i_start && !divisor_zero) next_state = ITER;
            end
            ITER: begin
                o_busy = 1'b1;
                if (count == CW'(WIDTH - 1)) next_state = FIX;
            end
            FIX: begin
                o_busy     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Divide-by-zero completes on the accept edge itself and never leaves IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            count         <= '0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor_zero) begin
                            o_quotient    <= '1;
                            o_remainder   <= i_dividend;
                            o_div_by_zero <= 1'b1;
                            o_done        <= 1'b1;
                        end else begin
                            q_reg  <= dividend_mag;
                            d_reg  <= divisor_mag;
                            r_reg  <= '0;
                            sign_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                            sign_r <= i_dividend[WIDTH-1];
                            count  <= '0;
                        end
                    end
                end
                ITER: begin
                    if (!trial[WIDTH]) begin
                        r_reg <= trial;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= r_shift;
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                end
                FIX: begin
                    o_quotient    <= sign_q ? -q_reg : q_reg;
                    o_remainder   <= sign_r ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
                    o_div_by_zero <= 1'b0;
                    o_done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed corner cases plus random
// operands checked against a plain-arithmetic signed division model.
module tb_sequential_divider;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prevQ, prevR;
    logic         prevZ;

    sequential_divider #(.WIDTH(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference: 64-bit signed arithmetic, truncating toward zero, sign of remainder follows dividend.
    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int pulseAt, input bit alreadyStarted);
        logic [W-1:0] eq, er;
        logic         ez;
        int           edges;
        int           busyCycles;
        refModel(a, b, eq, er, ez);
        if (!alreadyStarted) begin
            @(negedge i_clk);
            i_start    = 1'b1;
            i_dividend = a;
            i_divisor  = b;
        end
        @(negedge i_clk);
        i_start    = 1'b0;
        i_dividend = $urandom;
        i_divisor  = $urandom;
        edges      = 0;
        busyCycles = 0;
        if (b == '0) begin
            checkOutput("dbz_done", 64'(o_done), 64'd1);
            checkOutput("dbz_busy", 64'(o_busy), 64'd0);
        end else begin
            while (!o_done && edges < 100) begin
                if (o_busy) busyCycles++;
                if (edges == 3) begin
                    checkOutput("hold_quotient", 64'(o_quotient), 64'(prevQ));
                    checkOutput("hold_remainder", 64'(o_remainder), 64'(prevR));
                    checkOutput("hold_flag", 64'(o_div_by_zero), 64'(prevZ));
                end
                if (edges == pulseAt) begin
                    i_start    = 1'b1;
                    i_dividend = 32'd50;
                    i_divisor  = 32'd5;
                end else begin
                    i_start = 1'b0;
                end
                @(negedge i_clk);
                edges++;
            end
            i_start = 1'b0;
            checkOutput("latency", 64'(edges), 64'(W + 1));
            checkOutput("busy_cycles", 64'(busyCycles), 64'(W + 1));
            checkOutput("busy_after_done", 64'(o_busy), 64'd0);
        end
        checkOutput("quotient", 64'(o_quotient), 64'(eq));
        checkOutput("remainder", 64'(o_remainder), 64'(er));
        checkOutput("div_by_zero", 64'(o_div_by_zero), 64'(ez));
        prevQ = eq;
        prevR = er;
        prevZ = ez;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           sawDone;
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        prevQ      = '0;
        prevR      = '0;
        prevZ      = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("reset_busy", 64'(o_busy), 64'd0);
        checkOutput("reset_done", 64'(o_done), 64'd0);
        checkOutput("reset_quotient", 64'(o_quotient), 64'd0);
        checkOutput("reset_remainder", 64'(o_remainder), 64'd0);
        checkOutput("reset_flag", 64'(o_div_by_zero), 64'd0);
        i_rst = 1'b0;

        applyStimulus(32'd100, 32'd7, -1, 1'b0);
        applyStimulus(-32'sd100, 32'd7, -1, 1'b0);
        applyStimulus(32'd100, -32'sd7, -1, 1'b0);
        applyStimulus(-32'sd100, -32'sd7, -1, 1'b0);
        applyStimulus(32'd0, 32'd5, -1, 1'b0);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        checkOutput("min_over_neg1", 64'(o_quotient), 64'h8000_0000);
        applyStimulus(32'd5, 32'd9, -1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'd1, -1, 1'b0);
        applyStimulus(-32'sd12, 32'd0, -1, 1'b0);
        checkOutput("dbz_remainder_const", 64'(o_remainder), 64'hFFFF_FFF4);
        applyStimulus(32'd12, 32'd13, -1, 1'b0);

        // Start pulse mid-flight is ignored; start in the done cycle is taken.
        applyStimulus(32'd12, 32'd13, 10, 1'b0);
        i_start    = 1'b1;
        i_dividend = 32'd50;
        i_divisor  = 32'd5;
        applyStimulus(32'd50, 32'd5, -1, 1'b1);

        // Reset sampled at edge 15 of a 100/7 operation.
        @(negedge i_clk);
        i_start    = 1'b1;
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (14) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("abort_busy", 64'(o_busy), 64'd0);
        checkOutput("abort_done", 64'(o_done), 64'd0);
        checkOutput("abort_quotient", 64'(o_quotient), 64'd0);
        checkOutput("abort_remainder", 64'(o_remainder), 64'd0);
        checkOutput("abort_flag", 64'(o_div_by_zero), 64'd0);
        i_rst   = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", 64'(sawDone), 64'd0);
        prevQ = '0;
        prevR = '0;
        prevZ = 1'b0;
        applyStimulus(32'd100, 32'd7, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ($urandom_range(0, 1) != 0) ? -W'($urandom_range(1, 20)) : W'($urandom_range(1, 20));
                2: rb = '0;
                default: begin
                    ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : ra;
                    rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
                end
            endcase
            applyStimulus(ra, rb, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
